bf16_mul_accum: RTL and testbench

//  Sequential bfloat16 accumulator directly downstream of the bf16 multiplier (iv_fp_mul).

---
 rtl/bf16_mul_accum.sv | 237 +++++++++++++++++++++++
 tb/tb_bf16_mul_accum.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bf16_mul_accum.sv
// Sequential bfloat16 accumulator for a dot-product reduction: sums one vector of products
// with a multi-cycle align/add/normalise datapath, truncation rounding and a sticky error code.
module bf16_mul_accum #(
   parameter int DATA_WIDTH  = 16,
   parameter int EXP_WIDTH   = 8,
   parameter int FRAC_WIDTH  = 7,
   parameter int ERROR_WIDTH = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [ERROR_WIDTH-1:0] in_error,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [ERROR_WIDTH-1:0] out_error,
   output logic [CNT_WIDTH-1:0]   out_count
);
   // state  | meaning
   // S_IDLE | waiting for a product (in_ready high)
   // S_ALIGN| classify specials, align mantissas to the larger exponent
   // S_ADD  | signed-magnitude add/subtract
   // S_NORM | left-normalise one bit per cycle, write accumulator
   // S_OUT  | holding the vector result until out_ready
   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

   localparam int MW = FRAC_WIDTH + 4;
   localparam logic [EXP_WIDTH-1:0]   EXP_MAX = '1;
   localparam logic [DATA_WIDTH-1:0]  QNAN    = {1'b0, EXP_MAX, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
   localparam logic [ERROR_WIDTH-1:0] E_OK  = ERROR_WIDTH'(0);
   localparam logic [ERROR_WIDTH-1:0] E_OVF = ERROR_WIDTH'(1);
   localparam logic [ERROR_WIDTH-1:0] E_UNF = ERROR_WIDTH'(2);
   localparam logic [ERROR_WIDTH-1:0] E_NAN = ERROR_WIDTH'(3);

   function automatic logic [ERROR_WIDTH-1:0] merge(input logic [ERROR_WIDTH-1:0] a,
                                                    input logic [ERROR_WIDTH-1:0] b);
      if (a == E_NAN || b == E_NAN)      return E_NAN;
      else if (a == E_OVF || b == E_OVF) return E_OVF;
      else if (a == E_UNF || b == E_UNF) return E_UNF;
      else                               return E_OK;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] premap(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [ERROR_WIDTH-1:0] e);
      logic [EXP_WIDTH-1:0] ex;
      ex = d[DATA_WIDTH-2 -: EXP_WIDTH];
      if (e == E_NAN)        return QNAN;
      else if (e == E_OVF)   return {d[DATA_WIDTH-1], EXP_MAX, {FRAC_WIDTH{1'b0}}};
      else if (e == E_UNF)   return '0;
      else if (ex == '0)     return '0;
      else if (ex == EXP_MAX) return (d[FRAC_WIDTH-1:0] == '0) ? d : QNAN;
      else                   return d;
   endfunction

   state_t                 state;
   logic [DATA_WIDTH-1:0]  acc, op, spec_res;
   logic [ERROR_WIDTH-1:0] err;
   logic [CNT_WIDTH-1:0]   count;
   logic                   last_r, spec;
   logic [MW-1:0]          m_a, m_b, mant;
   logic                   s_a, s_b, sign_r, zero_r;
   logic [EXP_WIDTH:0]     e_r;

   logic [EXP_WIDTH-1:0]   a_exp, b_exp, er_c, d_c;
   logic [FRAC_WIDTH-1:0]  a_frac, b_frac;
   logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, spec_c, sa_c, sb_c;
   logic [DATA_WIDTH-1:0]  spec_val;
   logic [MW-1:0]          ma_c, mb_full, mb_c;

   always_comb begin
      a_exp   = acc[DATA_WIDTH-2 -: EXP_WIDTH];
      b_exp   = op[DATA_WIDTH-2 -: EXP_WIDTH];
      a_frac  = acc[FRAC_WIDTH-1:0];
      b_frac  = op[FRAC_WIDTH-1:0];
      a_nan   = (a_exp == EXP_MAX) && (a_frac != '0);
      b_nan   = (b_exp == EXP_MAX) && (b_frac != '0);
      a_inf   = (a_exp == EXP_MAX) && (a_frac == '0);
      b_inf   = (b_exp == EXP_MAX) && (b_frac == '0);
      a_zero  = (a_exp == '0);
      b_zero  = (b_exp == '0);
      spec_c  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
      spec_val = QNAN;
      if (a_nan || b_nan || (a_inf && b_inf && (acc[DATA_WIDTH-1] != op[DATA_WIDTH-1])))
         spec_val = QNAN;
      else if (a_inf)            spec_val = acc;
      else if (b_inf)            spec_val = op;
      else if (a_zero && b_zero) spec_val = '0;
      else if (a_zero)           spec_val = op;
      else                       spec_val = acc;
      if (a_exp >= b_exp) begin
         er_c    = a_exp;
         d_c     = a_exp - b_exp;
         ma_c    = {1'b1, a_frac, 3'b000};
         mb_full = {1'b1, b_frac, 3'b000};
         sa_c    = acc[DATA_WIDTH-1];
         sb_c    = op[DATA_WIDTH-1];
      end else begin
         er_c    = b_exp;
         d_c     = b_exp - a_exp;
         ma_c    = {1'b1, b_frac, 3'b000};
         mb_full = {1'b1, a_frac, 3'b000};
         sa_c    = op[DATA_WIDTH-1];
         sb_c    = acc[DATA_WIDTH-1];
      end
      mb_c = (d_c >= EXP_WIDTH'(MW)) ? '0 : (mb_full >> d_c);
   end

   logic [MW:0] sum_c;
   assign sum_c = {1'b0, m_a} + {1'b0, m_b};

   logic                   norm_done;
   logic [DATA_WIDTH-1:0]  norm_res;
   logic [ERROR_WIDTH-1:0] norm_err;

   always_comb begin
      norm_done = 1'b0;
      norm_res  = '0;
      norm_err  = err;
      if (spec) begin
         norm_done = 1'b1;
         norm_res  = spec_res;
      end else if (zero_r) begin
         norm_done = 1'b1;
      end else if (e_r >= {1'b0, EXP_MAX}) begin
         norm_done = 1'b1;
         norm_res  = {sign_r, EXP_MAX, {FRAC_WIDTH{1'b0}}};
         norm_err  = merge(err, E_OVF);
      end else if (mant[MW-1]) begin
         norm_done = 1'b1;
         norm_res  = {sign_r, e_r[EXP_WIDTH-1:0], mant[MW-2 -: FRAC_WIDTH]};
      end else if (e_r <= (EXP_WIDTH+1)'(1)) begin
         // the next shift would take the exponent to zero: flush rather than go denormal
         norm_done = 1'b1;
         norm_err  = merge(err, E_UNF);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         acc       <= '0;
         err       <= E_OK;
         count     <= '0;
         op        <= '0;
         last_r    <= 1'b0;
         spec      <= 1'b0;
         spec_res  <= '0;
         m_a       <= '0;
         m_b       <= '0;
         s_a       <= 1'b0;
         s_b       <= 1'b0;
         e_r       <= '0;
         mant      <= '0;
         sign_r    <= 1'b0;
         zero_r    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_error <= E_OK;
         out_count <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid && in_ready) begin
               op       <= premap(in_data, in_error);
               err      <= merge(err, in_error);
               last_r   <= in_last;
               if (count != '1) count <= count + 1'b1;
               in_ready <= 1'b0;
               state    <= S_ALIGN;
            end
            S_ALIGN: begin
               spec     <= spec_c;
               spec_res <= spec_val;
               m_a      <= ma_c;
               m_b      <= mb_c;
               s_a      <= sa_c;
               s_b      <= sb_c;
               e_r      <= {1'b0, er_c};
               state    <= S_ADD;
            end
            S_ADD: begin
               if (s_a == s_b) begin
                  zero_r <= 1'b0;
                  sign_r <= s_a;
                  if (sum_c[MW]) begin
                     mant <= sum_c[MW:1];
                     e_r  <= e_r + 1'b1;
                  end else begin
                     mant <= sum_c[MW-1:0];
                  end
               end else if (m_a >= m_b) begin
                  mant   <= m_a - m_b;
                  sign_r <= s_a;
                  zero_r <= (m_a == m_b);
               end else begin
                  mant   <= m_b - m_a;
                  sign_r <= s_b;
                  zero_r <= 1'b0;
               end
               state <= S_NORM;
            end
            S_NORM: begin
               if (norm_done) begin
                  acc <= norm_res;
                  err <= norm_err;
                  if (last_r) begin
                     out_valid <= 1'b1;
                     out_data  <= norm_res;
                     out_error <= norm_err;
                     out_count <= count;
                     state     <= S_OUT;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= S_IDLE;
                  end
               end else begin
                  mant <= {mant[MW-2:0], 1'b0};
                  e_r  <= e_r - 1'b1;
               end
            end
            S_OUT: if (out_ready) begin
               out_valid <= 1'b0;
               acc       <= '0;
               err       <= E_OK;
               count     <= '0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bf16_mul_accum.sv
// Directed bench for bf16_mul_accum: expected vector results are queued when the
// last element is driven and compared when out_valid is seen.
module tb_bf16_mul_accum;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic [15:0] in_data = '0;
   logic [1:0]  in_error = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [15:0] out_data;
   logic [1:0]  out_error;
   logic [7:0]  out_count;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  e;
      logic [7:0]  c;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   bf16_mul_accum dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_error(in_error), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_error(out_error), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $display("FAIL %s timeout observed none expected handshake", tag);
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] e, input logic l);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_error = e; in_last = l;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("in_ready");
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_error = '0;
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] e, input logic [7:0] c);
      exp_t x;
      x.d = d; x.e = e; x.c = c;
      sb.push_back(x);
   endtask

   task automatic recv(input string tag);
      int n;
      exp_t x;
      @(negedge clk);
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout(tag);
      else if (sb.size() == 0) timeout({tag, "_scoreboard_empty"});
      else begin
         x = sb.pop_front();
         chk({tag, "_data"},  32'(out_data),  32'(x.d));
         chk({tag, "_error"}, 32'(out_error), 32'(x.e));
         chk({tag, "_count"}, 32'(out_count), 32'(x.c));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic vec2(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d, input logic [1:0] e);
      push(d, e, 8'd2);
      send(a, 2'b00, 1'b0);
      send(b, 2'b00, 1'b1);
      recv(tag);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      rst = 1'b0;
      @(negedge clk);

      vec2("one_plus_two", 16'h3F80, 16'h4000, 16'h4040, 2'b00);
      vec2("cancel",       16'h4040, 16'hC040, 16'h0000, 2'b00);
      vec2("align_trunc",  16'h3F80, 16'h3B80, 16'h3F80, 2'b00);
      vec2("overflow",     16'h7F7F, 16'h7F7F, 16'h7F80, 2'b01);
      vec2("norm_shift",   16'h3FC0, 16'hBF80, 16'h3F00, 2'b00);
      vec2("underflow",    16'h00C0, 16'h8080, 16'h0000, 2'b10);

      push(16'h7FC0, 2'b11, 8'd1);
      send(16'h3F80, 2'b11, 1'b1);
      recv("nan_in");

      push(16'h3F80, 2'b10, 8'd2);
      send(16'h3F80, 2'b00, 1'b0);
      send(16'h4000, 2'b10, 1'b1);
      recv("err_unf_in");

      // back-pressure: result must hold while out_ready stays low
      push(16'h4040, 2'b00, 8'd2);
      send(16'h3F80, 2'b00, 1'b0);
      send(16'h4000, 2'b00, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("hold_wait");
      for (int i = 0; i < 10; i++) begin
         chk("hold_data",     32'(out_data),  32'h4040);
         chk("hold_count",    32'(out_count), 32'd2);
         chk("hold_valid",    32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready),  32'd0);
         @(negedge clk);
      end
      recv("hold_release");
      push(16'h3F80, 2'b00, 8'd1);
      send(16'h3F80, 2'b00, 1'b1);
      recv("after_hold");

      // reset while the third element is normalising
      send(16'h3F80, 2'b00, 1'b0);
      send(16'h4000, 2'b00, 1'b0);
      send(16'h3F80, 2'b00, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready",  32'(in_ready),  32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data",  32'(out_data),  32'h0);
      chk("midrst_out_error", 32'(out_error), 32'h0);
      chk("midrst_out_count", 32'(out_count), 32'h0);
      rst = 1'b0;
      vec2("post_rst", 16'h4000, 16'h4000, 16'h4080, 2'b00);

      push(16'h0000, 2'b00, 8'hFF);
      for (int i = 0; i < 255; i++) send(16'h0000, 2'b00, 1'b0);
      send(16'h0000, 2'b00, 1'b1);
      recv("count_sat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed no finish expected summary");
      $fatal(1, "watchdog");
   end
endmodule
